// File: rtl/link_credit_arbiter_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : link_credit_arbiter_if                                          |
// | Purpose  : Requester, link-side and status signals of link_credit_arbiter. |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
interface link_credit_arbiter_if #(
    parameter int DATA_WIDTH   = 256,
    parameter int NUM_REQ      = 3,
    parameter int CREDIT_WIDTH = 6
);
    logic                          link_ready;
    logic [NUM_REQ-1:0]            req_valid;
    logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
    logic [NUM_REQ-1:0]            req_grant;
    logic [DATA_WIDTH-1:0]         tx_data;
    logic                          credit_return;
    logic [CREDIT_WIDTH-1:0]       credits;
    logic                          credit_err;
    logic [NUM_REQ*8-1:0]          util;

    modport master (
        output link_ready, req_valid, req_data, credit_return,
        input  req_grant, tx_data, credits, credit_err, util
    );

    modport slave (
        input  link_ready, req_valid, req_data, credit_return,
        output req_grant, tx_data, credits, credit_err, util
    );
endinterface
`default_nettype wire

// File: rtl/link_credit_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : link_credit_arbiter                                             |
// | Purpose  : Round-robin, credit-gated sharing of one link TX port among     |
// |            NUM_REQ queues. Optional utilisation counters are built when    |
// |            LINK_CREDIT_ARBITER_UTIL_EN is defined.                         |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module link_credit_arbiter #(
    parameter int DATA_WIDTH   = 256,
    parameter int NUM_REQ      = 3,
    parameter int LINK_DELAY   = 20,
    parameter int CREDIT_MAX   = 44,
    parameter int CREDIT_WIDTH = 6
) (
    input  wire logic             clk,
    input  wire logic             rst,
    link_credit_arbiter_if.slave  bus
);

    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [CREDIT_WIDTH-1:0] c_credit_max = CREDIT_WIDTH'(CREDIT_MAX);
    localparam logic [CREDIT_WIDTH-1:0] c_credit_one = CREDIT_WIDTH'(1);
    localparam logic [DATA_WIDTH-1:0]   c_valid_bit  = {1'b1, {(DATA_WIDTH-1){1'b0}}};
    localparam logic [PTR_W-1:0]        c_ptr_init   = PTR_W'(NUM_REQ - 1);

    // The far-end FIFO must cover a full round trip plus margin.
    if (CREDIT_MAX < 2 * LINK_DELAY + 4) begin : g_cfg_check
        $error("link_credit_arbiter: CREDIT_MAX too small for LINK_DELAY");
    end

    typedef enum logic [1:0] {
        ST_LINK_DOWN = 2'd0,
        ST_RUN       = 2'd1,
        ST_STALL     = 2'd2
    } state_t;

    state_t                  state_q, state_d;
    logic [PTR_W-1:0]        ptr_q, ptr_d;
    logic [CREDIT_WIDTH-1:0] credits_q, credits_d;
    logic                    credit_err_q, credit_err_d;
    logic [DATA_WIDTH-1:0]   tx_data_q, tx_data_d;

    logic                    w_found;
    logic [PTR_W-1:0]        w_winner;
    int                      w_best_dist;
    logic                    w_grant_en;
    logic [NUM_REQ-1:0]      w_grant;
    logic [DATA_WIDTH-1:0]   w_sel_data;

    // Winner is the valid requester closest to ptr+1 going upward with wrap.
    always_comb begin
        w_found     = 1'b0;
        w_winner    = ptr_q;
        w_best_dist = NUM_REQ;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (bus.req_valid[i] &&
                ((i + NUM_REQ - 1 - int'(ptr_q)) % NUM_REQ) < w_best_dist) begin
                w_found     = 1'b1;
                w_winner    = PTR_W'(i);
                w_best_dist = (i + NUM_REQ - 1 - int'(ptr_q)) % NUM_REQ;
            end
        end
    end

    assign w_grant_en = (state_q == ST_RUN) && bus.link_ready &&
                        (credits_q != '0) && w_found;

    always_comb begin
        w_grant    = '0;
        w_sel_data = '0;
        if (w_grant_en) begin
            w_grant[w_winner] = 1'b1;
        end
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_grant[i]) begin
                w_sel_data = w_sel_data | bus.req_data[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    always_comb begin
        credits_d    = credits_q;
        credit_err_d = credit_err_q;
        if (w_grant_en && !bus.credit_return) begin
            credits_d = credits_q - c_credit_one;
        end else if (!w_grant_en && bus.credit_return) begin
            if (credits_q == c_credit_max) begin
                credit_err_d = 1'b1;
            end else begin
                credits_d = credits_q + c_credit_one;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        if (!bus.link_ready) begin
            state_d = ST_LINK_DOWN;
        end else begin
            case (state_q)
                ST_LINK_DOWN: state_d = ST_RUN;
                ST_RUN:       if (credits_d == '0) state_d = ST_STALL;
                ST_STALL:     if (credits_q != '0) state_d = ST_RUN;
                default:      state_d = ST_LINK_DOWN;
            endcase
        end
    end

    assign ptr_d     = w_grant_en ? w_winner : ptr_q;
    assign tx_data_d = w_grant_en ? (w_sel_data | c_valid_bit) : '0;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= ST_LINK_DOWN;
            ptr_q        <= c_ptr_init;
            credits_q    <= c_credit_max;
            credit_err_q <= 1'b0;
            tx_data_q    <= '0;
        end else begin
            state_q      <= state_d;
            ptr_q        <= ptr_d;
            credits_q    <= credits_d;
            credit_err_q <= credit_err_d;
            tx_data_q    <= tx_data_d;
        end
    end

    assign bus.req_grant  = w_grant;
    assign bus.tx_data    = tx_data_q;
    assign bus.credits    = credits_q;
    assign bus.credit_err = credit_err_q;

`ifdef LINK_CREDIT_ARBITER_UTIL_EN
    logic [7:0]           window_q, window_d;
    logic [NUM_REQ*8-1:0] cnt_q, cnt_d;
    logic [NUM_REQ*8-1:0] util_q, util_d;

    // A grant in the wrap cycle seeds the new window rather than the old one.
    always_comb begin
        window_d = window_q + 8'd1;
        cnt_d    = cnt_q;
        util_d   = util_q;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (window_q == 8'hFF) begin
                util_d[i*8 +: 8] = cnt_q[i*8 +: 8];
                cnt_d[i*8 +: 8]  = {7'd0, w_grant[i]};
            end else if (w_grant[i] && (cnt_q[i*8 +: 8] != 8'hFF)) begin
                cnt_d[i*8 +: 8]  = cnt_q[i*8 +: 8] + 8'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            window_q <= '0;
            cnt_q    <= '0;
            util_q   <= '0;
        end else begin
            window_q <= window_d;
            cnt_q    <= cnt_d;
            util_q   <= util_d;
        end
    end

    assign bus.util = util_q;
`else
    assign bus.util = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_link_credit_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_link_credit_arbiter                                          |
// | Purpose  : Directed stimulus with a cycle-level reference model of the     |
// |            arbiter's grant, launch, credit and utilisation rules.          |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module tb_link_credit_arbiter;

    localparam int DW   = 256;
    localparam int NR   = 3;
    localparam int CW   = 6;
    localparam int CMAX = 44;
    localparam int M_DOWN  = 0;
    localparam int M_RUN   = 1;
    localparam int M_STALL = 2;
    localparam logic [DW-1:0] MSB_BIT = {1'b1, {(DW-1){1'b0}}};
    localparam logic [DW-1:0] D0 = {8{32'h0123_4567}};
    localparam logic [DW-1:0] D1 = {8{32'hDEAD_BEEF}};
    localparam logic [DW-1:0] D2 = {8{32'h5A5A_A5A5}};

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    link_credit_arbiter_if #(.DATA_WIDTH(DW), .NUM_REQ(NR), .CREDIT_WIDTH(CW)) bus ();

    link_credit_arbiter #(
        .DATA_WIDTH(DW), .NUM_REQ(NR), .LINK_DELAY(20),
        .CREDIT_MAX(CMAX), .CREDIT_WIDTH(CW)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state
    int            m_state, m_credits, m_ptr, m_win;
    bit            m_err;
    logic [DW-1:0] m_tx;
    int            m_cnt [NR];
    int            m_util[NR];

    // Observed DUT grants, for the hand-computed sequence checks
    logic [NR-1:0] gq[$];
    int            n_grants = 0;

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h required %h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        m_state   = M_DOWN;
        m_credits = CMAX;
        m_ptr     = NR - 1;
        m_err     = 1'b0;
        m_tx      = '0;
        m_win     = 0;
        for (int i = 0; i < NR; i++) begin
            m_cnt[i]  = 0;
            m_util[i] = 0;
        end
    endtask

    function automatic int model_winner();
        if (m_state != M_RUN || !bus.link_ready || m_credits == 0) return -1;
        for (int k = 1; k <= NR; k++) begin
            int j;
            j = (m_ptr + k) % NR;
            if (bus.req_valid[j]) return j;
        end
        return -1;
    endfunction

    task automatic model_advance(input int g);
        int nc;
        nc = m_credits;
        if (g >= 0 && !bus.credit_return) nc = nc - 1;
        else if (g < 0 && bus.credit_return) begin
            if (m_credits == CMAX) m_err = 1'b1;
            else nc = nc + 1;
        end
        if (!bus.link_ready)                       m_state = M_DOWN;
        else if (m_state == M_DOWN)                m_state = M_RUN;
        else if (m_state == M_RUN && nc == 0)      m_state = M_STALL;
        else if (m_state == M_STALL && m_credits > 0) m_state = M_RUN;
        m_credits = nc;
        m_tx = (g >= 0) ? (bus.req_data[g*DW +: DW] | MSB_BIT) : '0;
        if (g >= 0) m_ptr = g;
`ifdef LINK_CREDIT_ARBITER_UTIL_EN
        for (int i = 0; i < NR; i++) begin
            if (m_win == 255) begin
                m_util[i] = m_cnt[i];
                m_cnt[i]  = (g == i) ? 1 : 0;
            end else if (g == i && m_cnt[i] < 255) begin
                m_cnt[i] = m_cnt[i] + 1;
            end
        end
        m_win = (m_win + 1) % 256;
`endif
    endtask

    always @(negedge clk) begin : p_cmp
        int            g;
        logic [NR-1:0] eg;
        logic [NR*8-1:0] eu;
        if (!rst) model_reset();
        g  = model_winner();
        eg = (g >= 0) ? NR'(1 << g) : '0;
        for (int i = 0; i < NR; i++) eu[i*8 +: 8] = m_util[i][7:0];
        chk("cyc_grant",      bus.req_grant,  eg);
        chk("cyc_tx_data",    bus.tx_data,    m_tx);
        chk("cyc_credits",    bus.credits,    m_credits);
        chk("cyc_credit_err", bus.credit_err, m_err);
        chk("cyc_util",       bus.util,       eu);
        if (bus.req_grant != '0) begin
            gq.push_back(bus.req_grant);
            n_grants++;
        end
        if (rst) model_advance(g);
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin : p_stim
        logic [NR-1:0] exp_order[6];
        int sz;
        exp_order = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100};

        // Reset with the link down and every requester waiting
        rst = 1'b0;
        bus.link_ready    = 1'b0;
        bus.req_valid     = 3'b111;
        bus.credit_return = 1'b0;
        bus.req_data      = {D2, D1, D0};
        tick(3);
        rst = 1'b1;
        tick(2);
        chk("t1_credits", bus.credits, 44);
        chk("t1_grant",   bus.req_grant, 0);
        chk("t1_tx_msb",  bus.tx_data[DW-1], 0);

        // Round-robin order once the link trains
        gq.delete();
        bus.link_ready = 1'b1;
        tick(8);
        for (int k = 0; k < 6; k++)
            chk("t2_order", (k < gq.size()) ? gq[k] : 3'b000, exp_order[k]);
        chk("t2_tx_last", bus.tx_data, D0 | MSB_BIT);

        // Drain all credits with a single requester, then one return
        rst = 1'b0;
        tick(1);
        rst = 1'b1;
        bus.req_valid = 3'b001;
        n_grants = 0;
        tick(60);
        chk("t3_grants",  n_grants, 44);
        chk("t3_credits", bus.credits, 0);
        bus.credit_return = 1'b1;
        tick(1);
        bus.credit_return = 1'b0;
        tick(6);
        chk("t3_one_more", n_grants, 45);
        chk("t3_credits0", bus.credits, 0);

        // Refill to 10, then grant and return together
        bus.req_valid     = 3'b000;
        bus.credit_return = 1'b1;
        tick(10);
        bus.credit_return = 1'b0;
        tick(2);
        chk("t4_refill", bus.credits, 10);
        bus.req_valid     = 3'b001;
        bus.credit_return = 1'b1;
        tick(1);
        bus.req_valid     = 3'b000;
        bus.credit_return = 1'b0;
        tick(2);
        chk("t4_same_cycle", bus.credits, 10);
        chk("t4_grants",     n_grants, 46);
        bus.credit_return = 1'b1;
        tick(34);
        chk("t4_full",    bus.credits, 44);
        chk("t4_no_err",  bus.credit_err, 0);
        tick(1);
        bus.credit_return = 1'b0;
        tick(2);
        chk("t4_sat",     bus.credits, 44);
        chk("t4_err",     bus.credit_err, 1);
        tick(5);
        chk("t4_sticky",  bus.credit_err, 1);
        rst = 1'b0;
        tick(1);
        chk("t4_err_rst", bus.credit_err, 0);
        rst = 1'b1;

        // Link drop mid-burst at 30 credits, then resume
        bus.req_valid = 3'b111;
        gq.delete();
        for (int c = 0; c < 100 && bus.credits != 6'd30; c++) tick(1);
        chk("t5_reach", bus.credits, 30);
        bus.link_ready = 1'b0;
        sz = gq.size();
        tick(5);
        chk("t5_hold",      bus.credits, 30);
        chk("t5_no_grants", gq.size() - sz, 0);
        chk("t5_last",      (sz > 0) ? gq[sz-1] : 3'b000, 3'b010);
        bus.link_ready = 1'b1;
        tick(3);
        chk("t5_resume",    (gq.size() > sz) ? gq[sz] : 3'b000, 3'b100);

        // Requester 1 alone with credits replenished every cycle
        rst = 1'b0;
        tick(1);
        rst = 1'b1;
        bus.req_valid     = 3'b010;
        bus.credit_return = 1'b1;
        tick(600);
        bus.credit_return = 1'b0;
        chk("t6_credits", bus.credits, 44);
`ifdef LINK_CREDIT_ARBITER_UTIL_EN
        chk("t6_util1", bus.util[15:8],  255);
        chk("t6_util0", bus.util[7:0],   0);
        chk("t6_util2", bus.util[23:16], 0);
`else
        chk("t6_util_off", bus.util, 0);
`endif
        tick(2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin : p_watchdog
        #200000;
        $display("FAIL watchdog: got timeout required completion");
        $fatal(1);
    end

endmodule
`default_nettype wire
